// File: rtl/pipeline_d_skid.sv
// -----------------------------------------------------------------------------
// pipeline_d_skid
// Two-entry skid buffer between the fetch and decode stages. It holds a main
// entry (M), which drives the decode-side outputs, and a skid entry (S), which
// catches the one extra instruction fetch can issue while decode stalls.
// in_ready comes straight from a register, so no combinational path runs from
// out_ready back to the fetch side.
//
// Handshake: a transfer happens on a posedge where valid and ready are both
// high. The producer holds valid and its payload steady until that transfer.
// accept = in_valid & in_ready, pop = out_valid & out_ready.
//
// Ports:
//   clk          single clock; all state changes on posedge
//   rst          synchronous active-low reset
//   flush        discard every held entry (branch/jump redirect)
//   in_valid     fetch presents an entry
//   in_ready     buffer can accept an entry (= !S.valid)
//   in_instr     fetched instruction
//   in_pc        PC of the fetched instruction
//   in_pcplus4   PC+4 of the fetched instruction
//   out_valid    head entry valid (= M.valid)
//   out_ready    decode consumes the head entry
//   out_instr    head instruction, or NOP_INSTR when empty
//   out_pc       head PC (keeps its last value when empty)
//   out_pcplus4  head PC+4 (keeps its last value when empty)
//   occupancy    number of valid entries held (0..2); also the state for debug
// -----------------------------------------------------------------------------
module pipeline_d_skid #(
  parameter int                  DATA_WIDTH    = 32,
  parameter int                  ADDRESS_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_instr,
  input  logic [ADDRESS_WIDTH-1:0] in_pc,
  input  logic [ADDRESS_WIDTH-1:0] in_pcplus4,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [ADDRESS_WIDTH-1:0] out_pcplus4,
  output logic [1:0]               occupancy
);

  logic                     m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]    m_instr_q, m_instr_d;
  logic [ADDRESS_WIDTH-1:0] m_pc_q, m_pc_d;
  logic [ADDRESS_WIDTH-1:0] m_pcp4_q, m_pcp4_d;

  logic                     s_valid_q, s_valid_d;
  logic [DATA_WIDTH-1:0]    s_instr_q, s_instr_d;
  logic [ADDRESS_WIDTH-1:0] s_pc_q, s_pc_d;
  logic [ADDRESS_WIDTH-1:0] s_pcp4_q, s_pcp4_d;

  logic accept;
  logic pop;

  assign in_ready  = ~s_valid_q;
  assign out_valid = m_valid_q;
  assign accept    = in_valid & ~s_valid_q;
  assign pop       = m_valid_q & out_ready;

  // S.valid implies M.valid, so the sum is never 3.
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

  // Payload registers stay as they are when an entry empties. out_pc and
  // out_pcplus4 therefore keep the last head value. Only out_instr is forced
  // to the bubble.
  assign out_instr   = m_valid_q ? m_instr_q : NOP_INSTR;
  assign out_pc      = m_pc_q;
  assign out_pcplus4 = m_pcp4_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_instr_d = m_instr_q;
    m_pc_d    = m_pc_q;
    m_pcp4_d  = m_pcp4_q;
    s_valid_d = s_valid_q;
    s_instr_d = s_instr_q;
    s_pc_d    = s_pc_q;
    s_pcp4_d  = s_pcp4_q;

    if (flush) begin
      // The handshakes in this cycle still complete on the ports. The entry
      // accepted in this cycle is dropped together with the held ones.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q) begin
      if (accept) begin
        m_valid_d = 1'b1;
        m_instr_d = in_instr;
        m_pc_d    = in_pc;
        m_pcp4_d  = in_pcplus4;
      end
    end else if (!s_valid_q) begin
      if (pop && accept) begin
        m_instr_d = in_instr;
        m_pc_d    = in_pc;
        m_pcp4_d  = in_pcplus4;
      end else if (pop) begin
        m_valid_d = 1'b0;
      end else if (accept) begin
        s_valid_d = 1'b1;
        s_instr_d = in_instr;
        s_pc_d    = in_pc;
        s_pcp4_d  = in_pcplus4;
      end
    end else if (pop) begin
      // Full: in_ready is low, so only a pop can move anything.
      m_instr_d = s_instr_q;
      m_pc_d    = s_pc_q;
      m_pcp4_d  = s_pcp4_q;
      s_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      m_instr_q <= '0;
      m_pc_q    <= '0;
      m_pcp4_q  <= '0;
      s_valid_q <= 1'b0;
      s_instr_q <= '0;
      s_pc_q    <= '0;
      s_pcp4_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_instr_q <= m_instr_d;
      m_pc_q    <= m_pc_d;
      m_pcp4_q  <= m_pcp4_d;
      s_valid_q <= s_valid_d;
      s_instr_q <= s_instr_d;
      s_pc_q    <= s_pc_d;
      s_pcp4_q  <= s_pcp4_d;
    end
  end

endmodule

// File: tb/tb_pipeline_d_skid.sv
// -----------------------------------------------------------------------------
// tb_pipeline_d_skid
// Bench for pipeline_d_skid. The reference model is a two-deep FIFO of
// expected entries. An accept pushes an entry, a pop checks the front entry,
// and a flush or reset empties the FIFO. Every cycle, the occupancy and
// ready/valid flags are compared against the FIFO depth.
// -----------------------------------------------------------------------------
module tb_pipeline_d_skid;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int W  = DW + 2 * AW;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_instr = '0;
  logic [AW-1:0] in_pc = '0;
  logic [AW-1:0] in_pcplus4 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pcplus4;
  logic [1:0]    occupancy;

  pipeline_d_skid #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_pcplus4(in_pcplus4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pcplus4(out_pcplus4),
    .occupancy(occupancy)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Each call starts at a negedge, applies the inputs, and returns at the next
  // negedge. The posedge between the two negedges samples the inputs.
  task automatic drive(input logic v, input logic [W-1:0] e, input logic r,
                       input logic f, input logic rs);
    in_valid   = v;
    {in_instr, in_pc, in_pcplus4} = e;
    out_ready  = r;
    flush      = f;
    rst        = rs;
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] mk(input logic [DW-1:0] instr, input logic [AW-1:0] pc);
    return {instr, pc, pc + 32'd4};
  endfunction

  function automatic logic [W-1:0] rnd_entry();
    logic [AW-1:0] pc;
    pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    return mk($urandom, pc);
  endfunction

  // ---------------- expected-queue producer ----------------
  always @(posedge clk) begin
    if (rst && !flush && in_valid && in_ready)
      exp_q.push_back({in_instr, in_pc, in_pcplus4});
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (chk_en && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", {out_instr, out_pc, out_pcplus4}, '0);
        end else begin
          check("pop_entry", {out_instr, out_pc, out_pcplus4}, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("occupancy", W'(occupancy), W'(exp_q.size()));
      check("in_ready_vs_occ", W'(in_ready), W'(occupancy < 2'd2));
      check("out_valid", W'(out_valid), W'(exp_q.size() > 0));
      if (!out_valid) check("idle_nop", W'(out_instr), W'(NOP));
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] ea, eb, ec;

  initial begin
    // Reset.
    @(negedge clk);
    drive(0, '0, 0, 0, 0);
    drive(0, '0, 0, 0, 0);
    chk_en = 1'b1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_occ",       W'(occupancy), W'(0));
    check("rst_out_instr", W'(out_instr), W'(NOP));
    check("rst_out_pc",    W'(out_pc),    W'(0));
    check("rst_out_pcp4",  W'(out_pcplus4), W'(0));

    // First accept in the first cycle after reset, visible one cycle later.
    drive(1, mk(32'h00A00093, 32'h100), 1, 0, 1);
    check("first_instr", W'(out_instr), W'(32'h00A00093));
    check("first_pc",    W'(out_pc),    W'(32'h100));
    check("first_pcp4",  W'(out_pcplus4), W'(32'h104));
    check("first_occ",   W'(occupancy), W'(1));
    drive(0, '0, 1, 0, 1);

    // Three entries back-to-back while decode stalls.
    ea = mk(32'hAAAA_0001, 32'h200);
    eb = mk(32'hBBBB_0002, 32'h204);
    ec = mk(32'hCCCC_0003, 32'h208);
    drive(1, ea, 0, 0, 1);
    drive(1, eb, 0, 0, 1);
    check("stall_occ2",     W'(occupancy), W'(2));
    check("stall_in_ready", W'(in_ready),  W'(0));
    drive(1, ec, 0, 0, 1);   // C held off
    check("stall_hold_occ", W'(occupancy), W'(2));
    check("stall_head_a",   W'(out_instr), W'(32'hAAAA_0001));
    drive(1, ec, 1, 0, 1);   // pop A; C is still refused
    drive(1, ec, 1, 0, 1);   // pop B, accept C
    drive(0, '0, 1, 0, 1);   // pop C
    check("stall_drained",  W'(occupancy), W'(0));

    // Streaming: one entry per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1, mk(32'h1000 + 32'(i), 32'h400 + 32'(4 * i)), 1, 0, 1);
      check("stream_occ", W'(occupancy), W'(1));
      check("stream_rdy", W'(in_ready),  W'(1));
      check("stream_instr", W'(out_instr), W'(32'h1000 + 32'(i)));
    end
    drive(0, '0, 1, 0, 1);

    // Flush while full, with a new entry offered in the flush cycle.
    drive(1, mk(32'h11, 32'h500), 0, 0, 1);
    drive(1, mk(32'h22, 32'h504), 0, 0, 1);
    check("pre_flush_occ", W'(occupancy), W'(2));
    drive(1, mk(32'h33, 32'h508), 0, 1, 1);
    check("flush_valid", W'(out_valid), W'(0));
    check("flush_instr", W'(out_instr), W'(NOP));
    check("flush_occ",   W'(occupancy), W'(0));
    check("flush_rdy",   W'(in_ready),  W'(1));
    drive(0, '0, 1, 0, 1);

    // Reset in the middle of a stream while full.
    drive(1, mk(32'h44, 32'h600), 0, 0, 1);
    drive(1, mk(32'h55, 32'h604), 0, 0, 1);
    drive(1, mk(32'h66, 32'h608), 1, 1, 0);
    check("mrst_valid", W'(out_valid), W'(0));
    check("mrst_pc",    W'(out_pc),    W'(0));
    check("mrst_instr", W'(out_instr), W'(NOP));
    check("mrst_rdy",   W'(in_ready),  W'(1));

    // Random traffic.
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 3) != 0, rnd_entry(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0, 1'b1);
    end

    // Drain the buffer and confirm that nothing is left over.
    drive(0, '0, 1, 0, 1);
    drive(0, '0, 1, 0, 1);
    check("drain_empty", W'(exp_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_d_skid.md
PIPELINE_D_SKID -- requirements
Module: pipeline_d_skid

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, instruction width in bits.
REQ-002 SHALL provide parameter ADDRESS_WIDTH, default 32, PC width in bits.
REQ-003 SHALL provide parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble instruction, width DATA_WIDTH.
REQ-004 SHALL provide port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL provide port rst  input  1  reset, synchronous, active-low: state resets at a posedge clk sampling rst==0.
REQ-006 SHALL provide port flush  input  1  discard all held entries (branch/jump redirect).
REQ-007 SHALL provide port in_valid  input  1  fetch side presents an entry.
REQ-008 SHALL provide port in_ready  output  1  block can accept an entry this cycle.
REQ-009 SHALL provide port in_instr  input  DATA_WIDTH  fetched instruction.
REQ-010 SHALL provide port in_pc  input  ADDRESS_WIDTH  PC of fetched instruction.
REQ-011 SHALL provide port in_pcplus4  input  ADDRESS_WIDTH  PC+4 of fetched instruction.
REQ-012 SHALL provide port out_valid  output  1  decode-side entry valid.
REQ-013 SHALL provide port out_ready  input  1  decode stage consumes entry this cycle.
REQ-014 SHALL provide ports out_instr (DATA_WIDTH), out_pc, out_pcplus4 (ADDRESS_WIDTH), outputs, head-entry payload.
REQ-015 SHALL provide port occupancy  output  2  number of valid entries held (0..2).

Function
REQ-016 SHALL hold two entries: main (M, drives out_*) and skid (S); invariant S.valid implies M.valid.
REQ-017 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready.
REQ-018 SHALL drive in_ready = !S.valid directly from registered state, with no combinational path from out_ready or in_valid.
REQ-019 SHALL drive out_valid = M.valid and occupancy = M.valid + S.valid.
REQ-020 SHALL drive out_instr = NOP_INSTR whenever M.valid==0; out_pc/out_pcplus4 SHALL retain the last M value in that case.
REQ-021 Flush==0 transitions SHALL be: M empty & accept -> M<=input.
REQ-022 M valid, S empty, pop & accept -> M<=input; pop & !accept -> M empties.
REQ-023 M valid, S empty, !pop & accept -> S<=input, M holds.
REQ-024 M valid, S valid, pop -> M<=S, S empties; !pop -> both hold.
REQ-025 SHALL deliver an accepted entry on out_* exactly 1 cycle after acceptance when empty, and sustain 1 entry/cycle when out_ready stays high.
REQ-026 SHALL preserve strict FIFO order; no entry is duplicated or lost except by flush/reset.
REQ-027 flush==1 SHALL clear M.valid and S.valid at the next posedge, with out_instr=NOP_INSTR the following cycle; an accept or pop in the same cycle completes as a handshake, but the accepted entry SHALL be discarded.
REQ-028 flush SHALL take priority over every transition in REQ-021..REQ-024.
REQ-029 Payload registers of an invalid entry SHALL NOT change observable outputs other than as stated in REQ-020.

Reset
REQ-030 rst==0 at a posedge SHALL force M.valid=0, S.valid=0, out_valid=0, in_ready=1, occupancy=0, out_instr=NOP_INSTR, out_pc=0, out_pcplus4=0.
REQ-031 Reset SHALL take priority over flush and all handshakes; entries accepted in the reset cycle SHALL be discarded.
REQ-032 The first accept after reset SHALL be possible in the first cycle with rst==1.

Verification
REQ-033 Reset then in_valid=1, instr=32'h00A00093, pc=0x100, pcplus4=0x104, out_ready=1 -> next cycle out_valid=1, out_instr=32'h00A00093, out_pc=0x100, occupancy=1.
REQ-034 Stream A,B,C back-to-back with out_ready=0 -> after A,B accepted: occupancy=2, in_ready=0, C held off; raise out_ready -> outputs A,B,C in order, none dropped.
REQ-035 Continuous in_valid=1, out_ready=1 for 8 entries -> one entry per cycle out, occupancy stays 1, in_ready stays 1.
REQ-036 occupancy=2 and flush=1 with in_valid=1 -> next cycle out_valid=0, out_instr=32'h00000013, occupancy=0, in_ready=1; flushed-cycle input never appears.
REQ-037 Mid-stream rst=0 with occupancy=2 -> next cycle out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1.
REQ-038 Random in_valid/out_ready/flush for 10k cycles -> scoreboard confirms order, no loss except flush, and in_ready==(occupancy<2) every cycle.
